// File: rtl/ram_2p_pipe.sv
// Shared-array two-port RAM: an LSU load/store port and a read-only fetch port,
// each with a configurable read latency, valid strobes and out-of-range flags.
module ram_2p_pipe #(
   parameter int                 DATA_W     = 32,
   parameter int                 DEPTH_LOG2 = 14,
   parameter int                 D_LAT      = 1,
   parameter int                 I_LAT      = 1,
   parameter logic [DATA_W-1:0]  NOP_WORD   = DATA_W'(32'h0000_0013)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // data (LSU) port
   input  logic                  ce_i,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   sel_i,
   input  logic [31:0]           addr_i,
   input  logic [DATA_W-1:0]     data_i,
   output logic [DATA_W-1:0]     data_o,
   output logic                  rvalid_o,
   output logic                  derr_o,
   // instruction fetch port
   input  logic                  inst_ce_i,
   input  logic [31:0]           pc_i,
   input  logic                  inst_flush_i,
   output logic [DATA_W-1:0]     ins_o,
   output logic                  ins_valid_o,
   output logic                  ierr_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LANES = DATA_W / 8;

   typedef logic [DEPTH_LOG2-1:0] idx_t;
   typedef logic [DATA_W-1:0]     word_t;

   word_t mem_q [DEPTH];

   logic   d_in_range, i_in_range;
   logic   wr_en, rd_en;
   idx_t   d_idx, i_idx;
   word_t  d_rd_word, i_rd_word;

   logic [D_LAT-1:0]  d_vld_d, d_vld_q, d_err_d, d_err_q;
   word_t [D_LAT-1:0] d_dat_d, d_dat_q;
   logic [I_LAT-1:0]  i_vld_d, i_vld_q, i_err_d, i_err_q;
   word_t [I_LAT-1:0] i_dat_d, i_dat_q;
   logic              wr_err_d, wr_err_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[1:0], pc_i[1:0]};

   // Address decode and array read; the fetch side sees a same-edge write (write-first).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      d_in_range = (addr_i[31:DEPTH_LOG2+2] == '0);
      i_in_range = (pc_i[31:DEPTH_LOG2+2] == '0);
      d_idx      = addr_i[DEPTH_LOG2+1:2];
      i_idx      = pc_i[DEPTH_LOG2+1:2];
      wr_en      = ce_i & we_i & d_in_range;
      rd_en      = ce_i & ~we_i;
      d_rd_word  = d_in_range ? mem_q[d_idx] : '0;
      i_rd_word  = i_in_range ? mem_q[i_idx] : '0;
      if (wr_en && i_in_range && (d_idx == i_idx)) begin
         for (int b = 0; b < LANES; b++) begin
            if (sel_i[b]) begin
               i_rd_word[8*b +: 8] = data_i[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      d_vld_d    = '0;
      d_err_d    = '0;
      d_dat_d    = '0;
      d_vld_d[0] = rd_en;
      d_err_d[0] = rd_en & ~d_in_range;
      d_dat_d[0] = d_rd_word;
      for (int k = 1; k < D_LAT; k++) begin
         d_vld_d[k] = d_vld_q[k-1];
         d_err_d[k] = d_err_q[k-1];
         d_dat_d[k] = d_dat_q[k-1];
      end
      wr_err_d = ce_i & we_i & ~d_in_range;
   end

   // A flush drops the fetch accepted at that edge and every entry still short of
   // the output stage; an entry moving into the output stage is already committed.
   always_comb begin
      i_vld_d    = '0;
      i_err_d    = '0;
      i_dat_d    = '0;
      i_vld_d[0] = inst_ce_i & ~inst_flush_i;
      i_err_d[0] = inst_ce_i & ~i_in_range;
      i_dat_d[0] = i_rd_word;
      for (int k = 1; k < I_LAT; k++) begin
         i_vld_d[k] = i_vld_q[k-1] & (~inst_flush_i | (k == I_LAT-1));
         i_err_d[k] = i_err_q[k-1];
         i_dat_d[k] = i_dat_q[k-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         d_vld_q  <= '0;
         d_err_q  <= '0;
         i_vld_q  <= '0;
         i_err_q  <= '0;
         wr_err_q <= 1'b0;
      end else begin
         d_vld_q  <= d_vld_d;
         d_err_q  <= d_err_d;
         i_vld_q  <= i_vld_d;
         i_err_q  <= i_err_d;
         wr_err_q <= wr_err_d;
      end
   end

   // NOTE: payload registers carry no reset; the outputs are gated by the reset valid bits.
   always_ff @(posedge clk_i) begin
      d_dat_q <= d_dat_d;
      i_dat_q <= i_dat_d;
   end

   // NOTE: the word array is never reset, so its contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < LANES; b++) begin
            if (sel_i[b]) begin
               mem_q[d_idx][8*b +: 8] <= data_i[8*b +: 8];
            end
         end
      end
   end

   assign rvalid_o    = d_vld_q[D_LAT-1];
   assign data_o      = rvalid_o ? d_dat_q[D_LAT-1] : '0;
   assign derr_o      = (rvalid_o & d_err_q[D_LAT-1]) | wr_err_q;
   assign ins_valid_o = i_vld_q[I_LAT-1];
   assign ins_o       = ins_valid_o ? i_dat_q[I_LAT-1] : NOP_WORD;
   assign ierr_o      = ins_valid_o & i_err_q[I_LAT-1];

   // Simulation back-door access to the array; these bypass both pipelines.
   function automatic bit simutil_get_mem(input int idx, output word_t val);
      val = '0;
      if (idx < 0 || idx >= DEPTH) return 1'b0;
      val = mem_q[idx[DEPTH_LOG2-1:0]];
      return 1'b1;
   endfunction

   task automatic simutil_set_mem(input int idx, input word_t val, output bit ok);
      ok = (idx >= 0) && (idx < DEPTH);
      if (ok) mem_q[idx[DEPTH_LOG2-1:0]] <= val;
   endtask

   task automatic simutil_memload(input word_t image [DEPTH]);
      for (int w = 0; w < DEPTH; w++) begin
         mem_q[idx_t'(w)] <= image[w];
      end
   endtask

endmodule

// File: tb/tb_ram_2p_pipe.sv
// Scoreboard bench for ram_2p_pipe: stimulus pushes expected returns, a negedge
// monitor pops and compares them, including the cycle each return must land on.
module tb_ram_2p_pipe;

   localparam int          DATA_W     = 32;
   localparam int          DEPTH_LOG2 = 14;
   localparam int          D_LAT      = 3;
   localparam int          I_LAT      = 2;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        ce_i = 1'b0, we_i = 1'b0;
   logic [3:0]  sel_i = '0;
   logic [31:0] addr_i = '0, data_i = '0, pc_i = '0;
   logic        inst_ce_i = 1'b0, inst_flush_i = 1'b0;
   logic [31:0] data_o, ins_o;
   logic        rvalid_o, derr_o, ins_valid_o, ierr_o;

   ram_2p_pipe #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .D_LAT      (D_LAT),
      .I_LAT      (I_LAT),
      .NOP_WORD   (NOP)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .ce_i         (ce_i),
      .we_i         (we_i),
      .sel_i        (sel_i),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .data_o       (data_o),
      .rvalid_o     (rvalid_o),
      .derr_o       (derr_o),
      .inst_ce_i    (inst_ce_i),
      .pc_i         (pc_i),
      .inst_flush_i (inst_flush_i),
      .ins_o        (ins_o),
      .ins_valid_o  (ins_valid_o),
      .ierr_o       (ierr_o)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t d_q[$];
   exp_t i_q[$];
   int   cyc      = 0;
   int   werr_due = -1;
   int   n_tests  = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares every cycle, away from the active edge.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i) begin
         check("rst_rvalid", 64'(rvalid_o), 64'd0);
         check("rst_ins_valid", 64'(ins_valid_o), 64'd0);
         check("rst_data", 64'(data_o), 64'd0);
         check("rst_ins", 64'(ins_o), 64'(NOP));
         check("rst_derr", 64'(derr_o), 64'd0);
         check("rst_ierr", 64'(ierr_o), 64'd0);
      end else begin
         if (rvalid_o) begin
            if (d_q.size() == 0) begin
               check("d_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
               e = d_q.pop_front();
               check("d_data", 64'(data_o), 64'(e.data));
               check("d_err", 64'(derr_o), 64'(e.err));
               check("d_latency", 64'(cyc), 64'(e.due));
            end
         end else begin
            check("d_idle_data", 64'(data_o), 64'd0);
            check("d_idle_derr", 64'(derr_o), 64'(cyc == werr_due));
            if (d_q.size() != 0 && d_q[0].due <= cyc) begin
               check("d_missing_rvalid", 64'd0, 64'd1);
               d_q.delete(0);
            end
         end
         if (ins_valid_o) begin
            if (i_q.size() == 0) begin
               check("i_unexpected_valid", 64'd1, 64'd0);
            end else begin
               e = i_q.pop_front();
               check("i_data", 64'(ins_o), 64'(e.data));
               check("i_err", 64'(ierr_o), 64'(e.err));
               check("i_latency", 64'(cyc), 64'(e.due));
            end
         end else begin
            check("i_idle_ins", 64'(ins_o), 64'(NOP));
            check("i_idle_ierr", 64'(ierr_o), 64'd0);
            if (i_q.size() != 0 && i_q[0].due <= cyc) begin
               check("i_missing_valid", 64'd0, 64'd1);
               i_q.delete(0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
      ce_i         = 1'b0;
      we_i         = 1'b0;
      sel_i        = '0;
      inst_ce_i    = 1'b0;
      inst_flush_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic oor);
      ce_i   = 1'b1;
      we_i   = 1'b1;
      addr_i = a;
      data_i = d;
      sel_i  = s;
      if (oor) werr_due = cyc + 1;
   endtask

   task automatic set_rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
      exp_t e;
      ce_i   = 1'b1;
      we_i   = 1'b0;
      addr_i = a;
      e.data = exp_d;
      e.err  = exp_e;
      e.due  = cyc + D_LAT;
      d_q.push_back(e);
   endtask

   task automatic set_fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                            input logic flush);
      exp_t e;
      inst_ce_i    = 1'b1;
      pc_i         = a;
      inst_flush_i = flush;
      e.data       = exp_d;
      e.err        = exp_e;
      e.due        = cyc + I_LAT;
      if (!flush) i_q.push_back(e);
   endtask

   initial begin
      idle(3);
      rst_i = 1'b0;
      idle(10);

      // partial-lane write merge, read at D_LAT
      set_wr(32'h100, 32'hDEAD_BEEF, 4'b1111, 1'b0); tick();
      set_wr(32'h100, 32'h0000_AA00, 4'b0010, 1'b0); tick();
      set_rd(32'h100, 32'hDEAD_AAEF, 1'b0);          tick();
      idle(5);

      set_wr(32'h0,  32'h1111_1111, 4'b1111, 1'b0); tick();
      set_wr(32'h4,  32'h2222_2222, 4'b1111, 1'b0); tick();
      set_wr(32'h8,  32'h3333_3333, 4'b1111, 1'b0); tick();
      set_wr(32'hC,  32'h4444_4444, 4'b1111, 1'b0); tick();
      set_wr(32'h40, 32'hFFFF_FFFF, 4'b1111, 1'b0); tick();

      // back-to-back pipelined reads
      set_rd(32'h0, 32'h1111_1111, 1'b0); tick();
      set_rd(32'h4, 32'h2222_2222, 1'b0); tick();
      set_rd(32'hC, 32'h4444_4444, 1'b0); tick();
      idle(5);

      // sel=0 writes nothing
      set_wr(32'h4, 32'hFFFF_FFFF, 4'b0000, 1'b0); tick();
      set_rd(32'h4, 32'h2222_2222, 1'b0);          tick();
      idle(5);

      // fetch flush on the third request's edge
      set_fetch(32'h0, 32'h1111_1111, 1'b0, 1'b0); tick();
      set_fetch(32'h4, 32'h2222_2222, 1'b0, 1'b0); tick();
      set_fetch(32'h8, 32'h3333_3333, 1'b0, 1'b1); tick();
      set_fetch(32'hC, 32'h4444_4444, 1'b0, 1'b0); tick();
      idle(5);

      // same-edge write and fetch, write-first
      set_wr(32'h40, 32'h1234_5678, 4'b1111, 1'b0);
      set_fetch(32'h40, 32'h1234_5678, 1'b0, 1'b0); tick();
      set_wr(32'h40, 32'h0000_00AB, 4'b0001, 1'b0);
      set_fetch(32'h40, 32'h1234_56AB, 1'b0, 1'b0); tick();
      set_rd(32'h40, 32'h1234_56AB, 1'b0);          tick();
      idle(5);

      // out-of-range read and write
      set_rd(32'h0010_0000, 32'h0, 1'b1);                    tick();
      idle(5);
      set_wr(32'h0010_0000, 32'hCAFE_F00D, 4'b1111, 1'b1);   tick();
      idle(2);
      set_rd(32'h0, 32'h1111_1111, 1'b0);                    tick();
      idle(5);

      // last in-range word and first out-of-range word, no aliasing
      set_wr(32'hFFFC, 32'h5A5A_5A5A, 4'b1111, 1'b0);        tick();
      set_rd(32'hFFFC, 32'h5A5A_5A5A, 1'b0);                 tick();
      set_rd(32'h0001_0000, 32'h0, 1'b1);                    tick();
      set_fetch(32'h0001_0000, 32'h0, 1'b1, 1'b0);           tick();
      set_fetch(32'hFFFC, 32'h5A5A_5A5A, 1'b0, 1'b0);        tick();
      idle(5);
      set_wr(32'h0001_0000, 32'hBAD0_BAD0, 4'b1111, 1'b1);   tick();
      idle(2);
      set_rd(32'h0, 32'h1111_1111, 1'b0);                    tick();
      idle(5);

      // reset with two reads in flight
      set_rd(32'h100, 32'hDEAD_AAEF, 1'b0); tick();
      set_rd(32'h0,   32'h1111_1111, 1'b0); tick();
      rst_i = 1'b1;
      d_q.delete();
      i_q.delete();
      idle(2);
      rst_i = 1'b0;
      idle(6);
      set_rd(32'h100, 32'hDEAD_AAEF, 1'b0); tick();
      idle(6);

      check("d_queue_drained", 64'(d_q.size()), 64'd0);
      check("i_queue_drained", 64'(i_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
